// File: rtl/bus_sched_pkg.sv
// bus_sched_pkg: shared FSM state type and destination-ID width for the bus scheduler
package bus_sched_pkg;
  typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;
  localparam int DEST_W = 8;
endpackage

// File: rtl/bus_rr_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from last+1 with wrap
// req: request vector; last: previous grant index; gnt: one-hot grant; idx: grant index; vld: any request
module rr_arbiter #(
  parameter int drvrs = 4
) (
  input  logic [drvrs-1:0] req,
  input  logic [3:0]       last,
  output logic [drvrs-1:0] gnt,
  output logic [3:0]       idx,
  output logic             vld
);
  int best_d;
  int d;
  always_comb begin
    best_d = drvrs;
    d = 0;
    idx = last;
    vld = 1'b0;
    gnt = '0;
    for (int i = 0; i < drvrs; i++) begin
      // distance of terminal i from last+1 along the wrapped search order
      d = (i + 2 * drvrs - int'(last) - 1) % drvrs;
      if (req[i] && d < best_d) begin
        best_d = d;
        idx = 4'(i);
        vld = 1'b1;
      end
    end
    for (int i = 0; i < drvrs; i++) gnt[i] = vld && idx == 4'(i);
  end
endmodule

// File: rtl/bus_rr_sched.sv
// bus_rr_sched: round-robin bus scheduler moving one packet per 3 cycles (IDLE/POP/PUSH)
// in:  clk, reset (async active-low), pndng (per-terminal FIFO non-empty), D_pop (FIFO head words)
// out: pop/push strobes, D_push packet, busy, grant_id, drop_cnt (saturating)
module bus_rr_sched
  import bus_sched_pkg::*;
#(
  parameter int                drvrs     = 4,
  parameter int                pckg_sz   = 16,
  parameter logic [DEST_W-1:0] broadcast = 8'hFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [drvrs-1:0]         pndng,
  input  logic [drvrs*pckg_sz-1:0] D_pop,
  output logic [drvrs-1:0]         pop,
  output logic [drvrs-1:0]         push,
  output logic [pckg_sz-1:0]       D_push,
  output logic                     busy,
  output logic [3:0]               grant_id,
  output logic [7:0]               drop_cnt
);
  state_t state_q, state_d;
  logic [drvrs-1:0] pop_q, pop_d, push_q, push_d, arb_gnt;
  logic [pckg_sz-1:0] d_push_q, d_push_d, head;
  logic busy_q, busy_d, arb_vld;
  logic [3:0] grant_q, grant_d, last_q, last_d, arb_idx;
  logic [7:0] drop_q, drop_d;
  logic [DEST_W-1:0] dest;
  logic [drvrs-1:0] one;
  rr_arbiter #(.drvrs(drvrs)) u_arb (
    .req (pndng),
    .last(last_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .vld (arb_vld)
  );
  assign one = {{(drvrs-1){1'b0}}, 1'b1};
  assign head = D_pop[int'(grant_q)*pckg_sz +: pckg_sz];
  assign dest = head[pckg_sz-1 -: DEST_W];
  always_comb begin
    state_d = state_q;
    pop_d = '0;
    push_d = '0;
    d_push_d = d_push_q;
    busy_d = busy_q;
    grant_d = grant_q;
    last_d = last_q;
    drop_d = drop_q;
    case (state_q)
      IDLE: if (arb_vld) begin
        state_d = POP;
        pop_d = arb_gnt;
        grant_d = arb_idx;
        last_d = arb_idx;
        busy_d = 1'b1;
      end
      POP: begin
        state_d = PUSH;
        d_push_d = head;
        // pop_q is the one-hot grant here, so its complement is every other terminal
        if (dest == broadcast) push_d = ~pop_q;
        else if (int'(dest) < drvrs && dest != {4'b0, grant_q}) push_d = one << dest;
        else drop_d = drop_q == 8'hFF ? drop_q : drop_q + 8'd1;
      end
      PUSH: begin
        state_d = IDLE;
        busy_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pop_q <= '0;
      push_q <= '0;
      d_push_q <= '0;
      busy_q <= 1'b0;
      grant_q <= '0;
      last_q <= 4'(drvrs - 1);
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      pop_q <= pop_d;
      push_q <= push_d;
      d_push_q <= d_push_d;
      busy_q <= busy_d;
      grant_q <= grant_d;
      last_q <= last_d;
      drop_q <= drop_d;
    end
  end
  assign pop = pop_q;
  assign push = push_q;
  assign D_push = d_push_q;
  assign busy = busy_q;
  assign grant_id = grant_q;
  assign drop_cnt = drop_q;
endmodule

// File: tb/tb_bus_rr_sched.sv
// tb_bus_rr_sched: random and directed stimulus checked against a transaction-level model
module tb_bus_rr_sched;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] pndng = '0;
  logic [63:0] d_pop = '0;
  logic [3:0] pop, push, grant_id;
  logic [15:0] D_push;
  logic busy;
  logic [7:0] drop_cnt;
  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;
  bus_rr_sched dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop),
    .pop(pop), .push(push), .D_push(D_push), .busy(busy),
    .grant_id(grant_id), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  function automatic int rr_pick(input logic [3:0] req, input int last);
    for (int k = 1; k <= 4; k++) if (req[(last + k) % 4]) return (last + k) % 4;
    return last;
  endfunction
  function automatic logic [3:0] dest_mask(input logic [15:0] pkt, input int g);
    int dst;
    dst = int'(pkt[15:8]);
    if (dst == 255) return 4'hF & ~4'(1 << g);
    if (dst < 4 && dst != g) return 4'(1 << dst);
    return 4'h0;
  endfunction
  int m_ph, m_last, m_g, e_drop;
  logic [3:0] e_pop, e_push, e_gid;
  logic [15:0] e_dp;
  logic e_busy;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ph <= 0; m_last <= 3; m_g <= 0; e_pop <= 0; e_push <= 0;
      e_gid <= 0; e_dp <= 0; e_busy <= 0; e_drop <= 0;
    end else begin
      e_pop <= 0;
      e_push <= 0;
      if (m_ph == 1) begin
        e_dp <= d_pop[m_g*16 +: 16];
        e_push <= dest_mask(d_pop[m_g*16 +: 16], m_g);
        if (dest_mask(d_pop[m_g*16 +: 16], m_g) == 0 && e_drop < 255) e_drop <= e_drop + 1;
        m_ph <= 2;
      end else if (m_ph == 2) begin
        m_ph <= 0;
        e_busy <= 0;
      end else if (pndng != 0) begin
        m_g <= rr_pick(pndng, m_last);
        m_last <= rr_pick(pndng, m_last);
        e_gid <= 4'(rr_pick(pndng, m_last));
        e_pop <= 4'(1 << rr_pick(pndng, m_last));
        e_busy <= 1;
        m_ph <= 1;
      end
    end
  end
  always @(negedge clk) if (chk_en) begin
    total++;
    if ({pop, push, D_push, busy, grant_id, drop_cnt} !== {e_pop, e_push, e_dp, e_busy, e_gid, 8'(e_drop)}) begin
      bad++;
      $display("FAIL model t=%0t: got pop=%h push=%h dp=%h busy=%b gid=%0d drop=%0d want pop=%h push=%h dp=%h busy=%b gid=%0d drop=%0d",
        $time, pop, push, D_push, busy, grant_id, drop_cnt, e_pop, e_push, e_dp, e_busy, e_gid, e_drop);
    end
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic do_reset();
    #1 reset = 1'b0;
    tick(2);
    reset = 1'b1;
  endtask
  int exp_g[5] = '{0, 1, 2, 3, 0};
  initial begin
    tick(3);
    reset = 1'b1;
    chk_en = 1'b1;
    chk("rst_pop", 32'(pop), 0);
    chk("rst_push", 32'(push), 0);
    chk("rst_dpush", 32'(D_push), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    d_pop[16 +: 16] = 16'h0355;
    pndng = 4'b0010;
    tick(1);
    chk("s1_pop", 32'(pop), 32'h2);
    chk("s1_busy0", 32'(busy), 1);
    pndng = 4'b0000;
    tick(1);
    chk("s1_push", 32'(push), 32'h8);
    chk("s1_dpush", 32'(D_push), 32'h0355);
    chk("s1_busy1", 32'(busy), 1);
    tick(1);
    chk("s1_idle", 32'(busy), 0);
    chk("s1_hold", 32'(D_push), 32'h0355);
    do_reset();
    d_pop = {16'h0044, 16'h0333, 16'h0222, 16'h0111};
    pndng = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      tick(j == 0 ? 1 : 3);
      chk("s2_pop", 32'(pop), 32'(1 << exp_g[j]));
      chk("s2_gid", 32'(grant_id), 32'(exp_g[j]));
    end
    pndng = 4'b0000;
    tick(3);
    d_pop[32 +: 16] = 16'hFFAA;
    pndng = 4'b0100;
    tick(1);
    pndng = 4'b0000;
    tick(1);
    chk("s3_push", 32'(push), 32'hB);
    chk("s3_dpush", 32'(D_push), 32'hFFAA);
    tick(1);
    chk("s4_drop0", 32'(drop_cnt), 0);
    d_pop[0 +: 16] = 16'h0755;
    pndng = 4'b0001;
    tick(1);
    pndng = 4'b0000;
    tick(1);
    chk("s4_push_a", 32'(push), 0);
    chk("s4_drop1", 32'(drop_cnt), 1);
    tick(1);
    d_pop[0 +: 16] = 16'h0012;
    pndng = 4'b0001;
    tick(1);
    pndng = 4'b0000;
    tick(1);
    chk("s4_push_b", 32'(push), 0);
    chk("s4_drop2", 32'(drop_cnt), 2);
    tick(1);
    pndng = 4'b0100;
    tick(1);
    chk("s5_inpop", 32'(pop), 32'h4);
    #1 reset = 1'b0;
    #1;
    chk("s5_pop", 32'(pop), 0);
    chk("s5_push", 32'(push), 0);
    chk("s5_busy", 32'(busy), 0);
    tick(1);
    reset = 1'b1;
    pndng = 4'b1000;
    tick(1);
    chk("s5_g3", 32'(grant_id), 3);
    chk("s5_pop3", 32'(pop), 32'h8);
    pndng = 4'b1001;
    tick(3);
    chk("s5_g0", 32'(grant_id), 0);
    chk("s5_pop0", 32'(pop), 32'h1);
    pndng = 4'b0000;
    tick(3);
    for (int c = 0; c < 1500; c++) begin
      pndng = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        logic [7:0] dst;
        int sel;
        sel = int'($urandom_range(0, 5));
        dst = sel < 4 ? 8'(sel) : sel == 4 ? 8'hFF : 8'($urandom);
        d_pop[i*16 +: 16] = {dst, 8'($urandom)};
      end
      tick(1);
    end
    pndng = 4'b0000;
    tick(3);
    d_pop[0 +: 16] = 16'h0755;
    pndng = 4'b0001;
    tick(905);
    chk("s6_sat", 32'(drop_cnt), 255);
    tick(30);
    chk("s6_hold", 32'(drop_cnt), 255);
    pndng = 4'b0000;
    tick(3);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
